// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase sequencer and the phase diagram overlay:
// excitation modes, sequencer states and the half-step coil table.
package stepper_pkg;

    typedef enum logic [1:0] {
        MODE_WAVE = 2'd0,
        MODE_TWO  = 2'd1,
        MODE_HALF = 2'd2,
        MODE_OFF  = 2'd3
    } mode_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    // Coil bus is {/B, /A, B, A}
    localparam int COIL_A  = 0;
    localparam int COIL_B  = 1;
    localparam int COIL_NA = 2;
    localparam int COIL_NB = 3;

    // Entry [i] is the coil pattern for half-step index i (entry 7 listed first)
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'd9, 4'd8, 4'd12, 4'd4, 4'd6, 4'd2, 4'd3, 4'd1
    };

    function automatic logic [3:0] phase_coil(input logic [2:0] idx);
        return PHASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/stepper_next_index.sv
// Combinational next half-step index for a given excitation mode and direction.
// Wave mode lands on even indices, two-phase on odd ones; a wrong-parity start realigns.
module stepper_next_index
    import stepper_pkg::*;
(
    input  logic [2:0] idx,
    input  mode_e      mode,
    input  logic       dir,
    output logic [2:0] next_idx
);

    logic [2:0] inc1_s;
    logic [2:0] inc2_s;
    logic [2:0] dec1_s;
    logic [2:0] dec2_s;

    assign inc1_s = idx + 3'd1;
    assign inc2_s = idx + 3'd2;
    assign dec1_s = idx - 3'd1;
    assign dec2_s = idx - 3'd2;

    // Select the successor index; arithmetic wraps modulo 8
    always_comb begin
        next_idx = idx;
        case (mode)
            MODE_WAVE: begin
                if (dir) begin
                    next_idx = inc2_s & 3'b110;
                end else begin
                    next_idx = dec1_s & 3'b110;
                end
            end
            MODE_TWO: begin
                if (dir) begin
                    next_idx = (inc1_s & 3'b110) + 3'd1;
                end else begin
                    next_idx = dec2_s | 3'b001;
                end
            end
            MODE_HALF: begin
                if (dir) begin
                    next_idx = inc1_s;
                end else begin
                    next_idx = dec1_s;
                end
            end
            MODE_OFF: next_idx = idx;
            default:  next_idx = idx;
        endcase
    end

endmodule

// File: rtl/stepper_phase_sequencer.sv
// Command-driven stepper coil sequencer: paces half-step table changes at the commanded
// period, tracks position, and holds the coils energised for a while after each move.
module stepper_phase_sequencer
    import stepper_pkg::*;
#(
    parameter int STEP_BITS   = 16,
    parameter int PERIOD_BITS = 24,
    parameter int HOLD_CYCLES = 2_700_000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [STEP_BITS-1:0]   cmd_steps,
    input  logic                   cmd_dir,
    input  logic [1:0]             cmd_mode,
    input  logic [PERIOD_BITS-1:0] cmd_period,
    input  logic                   abort,
    output logic [3:0]             coil,
    output logic                   drv_enable,
    output logic [2:0]             phase_index,
    output logic [STEP_BITS-1:0]   position,
    output logic [STEP_BITS-1:0]   steps_remaining,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);

    state_t                 state_q,   state_d;
    mode_e                  mode_q,    mode_d;
    logic                   dir_q,     dir_d;
    logic [PERIOD_BITS-1:0] period_q,  period_d;
    logic [PERIOD_BITS-1:0] cnt_q,     cnt_d;
    logic [HOLD_W-1:0]      hold_q,    hold_d;
    logic [2:0]             phase_q,   phase_d;
    logic [STEP_BITS-1:0]   pos_q,     pos_d;
    logic [STEP_BITS-1:0]   steps_q,   steps_d;
    logic [3:0]             coil_q,    coil_d;
    logic                   drv_q,     drv_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic                   aborted_q, aborted_d;

    logic [2:0]             next_idx_s;
    logic                   accept_s;
    logic                   step_fire_s;
    logic                   to_hold_s;
    mode_e                  cmd_mode_s;

    stepper_next_index u_next_index (
        .idx      (phase_q),
        .mode     (mode_q),
        .dir      (dir_q),
        .next_idx (next_idx_s)
    );

    assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign accept_s    = cmd_valid && cmd_ready;
    assign step_fire_s = (cnt_q == (period_q - PERIOD_BITS'(1)));
    assign cmd_mode_s  = mode_e'(cmd_mode);

    // Next-state logic for the sequencer FSM and all datapath registers
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        phase_d   = phase_q;
        pos_d     = pos_q;
        steps_d   = steps_q;
        coil_d    = coil_q;
        drv_d     = drv_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        to_hold_s = 1'b0;

        case (state_q)
            ST_RUN: begin
                // abort outranks a step due on the same edge
                if (abort) begin
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    to_hold_s = 1'b1;
                end else if (step_fire_s) begin
                    cnt_d   = '0;
                    phase_d = next_idx_s;
                    coil_d  = phase_coil(next_idx_s);
                    pos_d   = dir_q ? (pos_q + STEP_BITS'(1)) : (pos_q - STEP_BITS'(1));
                    steps_d = steps_q - STEP_BITS'(1);
                    if (steps_q == STEP_BITS'(1)) begin
                        done_d    = 1'b1;
                        to_hold_s = 1'b1;
                    end else begin
                        to_hold_s = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_BITS'(1);
                end
            end
            ST_IDLE, ST_HOLD: begin
                if (state_q == ST_HOLD) begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        coil_d  = 4'd0;
                        drv_d   = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    hold_d = hold_q;
                end
                // An accept here overrides any release computed above
                if (accept_s) begin
                    mode_d   = cmd_mode_s;
                    dir_d    = cmd_dir;
                    period_d = (cmd_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : cmd_period;
                    steps_d  = cmd_steps;
                    cnt_d    = '0;
                    if (cmd_mode_s == MODE_OFF) begin
                        state_d = ST_IDLE;
                        coil_d  = 4'd0;
                        drv_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (cmd_steps == '0) begin
                        coil_d  = coil_q;
                        drv_d   = drv_q;
                        done_d  = 1'b1;
                        if (drv_q) begin
                            to_hold_s = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_RUN;
                        coil_d  = phase_coil(phase_q);
                        drv_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                coil_d  = 4'd0;
                drv_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (to_hold_s) begin
            busy_d = 1'b0;
            hold_d = '0;
            if (HOLD_EN) begin
                state_d = ST_HOLD;
            end else begin
                state_d = ST_IDLE;
                coil_d  = 4'd0;
                drv_d   = 1'b0;
            end
        end else begin
            hold_d = hold_d;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_WAVE;
            dir_q     <= 1'b0;
            period_q  <= PERIOD_BITS'(2);
            cnt_q     <= '0;
            hold_q    <= '0;
            phase_q   <= 3'd0;
            pos_q     <= '0;
            steps_q   <= '0;
            coil_q    <= 4'd0;
            drv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            steps_q   <= steps_d;
            coil_q    <= coil_d;
            drv_q     <= drv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign coil            = coil_q;
    assign drv_enable      = drv_q;
    assign phase_index     = phase_q;
    assign position        = pos_q;
    assign steps_remaining = steps_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Directed bench for stepper_phase_sequencer with a short hold time; outputs are
// sampled on the falling edge, commands are driven there and accepted on the next rising edge.
module tb_stepper_phase_sequencer;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [1:0]  cmd_mode;
    logic [23:0] cmd_period;
    logic        abort;
    logic [3:0]  coil;
    logic        drv_enable;
    logic [2:0]  phase_index;
    logic [15:0] position;
    logic [15:0] steps_remaining;
    logic        busy;
    logic        done;
    logic        aborted;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [3:0] TBL [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd4, 4'd12, 4'd8, 4'd9};

    stepper_phase_sequencer #(
        .STEP_BITS   (16),
        .PERIOD_BITS (24),
        .HOLD_CYCLES (16)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_steps       (cmd_steps),
        .cmd_dir         (cmd_dir),
        .cmd_mode        (cmd_mode),
        .cmd_period      (cmd_period),
        .abort           (abort),
        .coil            (coil),
        .drv_enable      (drv_enable),
        .phase_index     (phase_index),
        .position        (position),
        .steps_remaining (steps_remaining),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge
    task automatic send(input logic [15:0] steps, input logic dir, input logic [1:0] mode,
                        input logic [23:0] period);
        cmd_steps  = steps;
        cmd_dir    = dir;
        cmd_mode   = mode;
        cmd_period = period;
        cmd_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = 1'b1;
        cmd_steps  = 16'd5;
        cmd_dir    = 1'b1;
        cmd_mode   = 2'd2;
        cmd_period = 24'd4;
        abort      = 1'b0;
        tick(3);
        chk("rst_coil", {28'd0, coil}, 32'd0);
        chk("rst_drv", {31'd0, drv_enable}, 32'd0);
        chk("rst_idx", {29'd0, phase_index}, 32'd0);
        chk("rst_pos", {16'd0, position}, 32'd0);
        chk("rst_steps", {16'd0, steps_remaining}, 32'd0);
        chk("rst_busy", {29'd0, busy, done, aborted}, 32'd0);
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        tick(1);

        // Half-step forward, 8 steps, period 4
        send(16'd8, 1'b1, 2'd2, 24'd4);
        chk("t1_acc_coil", {28'd0, coil}, 32'd1);
        chk("t1_acc_busy", {30'd0, busy, drv_enable}, 32'd3);
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            chk("t1_coil", {28'd0, coil}, {28'd0, TBL[(k / 4) % 8]});
            chk("t1_done", {31'd0, done}, (k == 32) ? 32'd1 : 32'd0);
        end
        chk("t1_pos", {16'd0, position}, 32'd8);
        chk("t1_idx", {29'd0, phase_index}, 32'd0);
        chk("t1_steps", {16'd0, steps_remaining}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_drv", {31'd0, drv_enable}, 32'd1);

        // Two-phase reverse from index 0, 3 steps, period 2
        do_reset();
        chk("t2_rst_pos", {16'd0, position}, 32'd0);
        send(16'd3, 1'b0, 2'd1, 24'd2);
        tick(1);
        chk("t2_coil_hold", {28'd0, coil}, 32'd1);
        tick(1);
        chk("t2_idx1", {29'd0, phase_index}, 32'd7);
        chk("t2_coil1", {28'd0, coil}, 32'd9);
        tick(2);
        chk("t2_idx2", {29'd0, phase_index}, 32'd5);
        chk("t2_coil2", {28'd0, coil}, 32'd12);
        tick(2);
        chk("t2_idx3", {29'd0, phase_index}, 32'd3);
        chk("t2_coil3", {28'd0, coil}, 32'd6);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_pos", {16'd0, position}, 32'h0000_FFFD);

        // Wave forward from index 3, accepted while holding
        send(16'd2, 1'b1, 2'd0, 24'd3);
        chk("t3_acc_coil", {28'd0, coil}, 32'd6);
        tick(3);
        chk("t3_idx1", {29'd0, phase_index}, 32'd4);
        chk("t3_coil1", {28'd0, coil}, 32'd4);
        tick(3);
        chk("t3_idx2", {29'd0, phase_index}, 32'd6);
        chk("t3_coil2", {28'd0, coil}, 32'd8);
        chk("t3_steps", {16'd0, steps_remaining}, 32'd0);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_pos", {16'd0, position}, 32'h0000_FFFF);

        // Abort on the edge of the 3rd of 10 half-steps
        send(16'd10, 1'b1, 2'd2, 24'd2);
        tick(5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t4_idx", {29'd0, phase_index}, 32'd0);
        chk("t4_steps", {16'd0, steps_remaining}, 32'd8);
        chk("t4_pulses", {30'd0, done, aborted}, 32'd3);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_energised", {27'd0, drv_enable, coil}, 32'h11);
        chk("t4_pos", {16'd0, position}, 32'd1);
        chk("t4_ready", {31'd0, cmd_ready}, 32'd1);
        tick(1);
        chk("t4_pulse_end", {30'd0, done, aborted}, 32'd0);

        // Release exactly 16 clocks after done
        tick(14);
        chk("t5_still_on", {27'd0, drv_enable, coil}, 32'h11);
        tick(1);
        chk("t5_released", {27'd0, drv_enable, coil}, 32'h00);
        chk("t5_idx_kept", {29'd0, phase_index}, 32'd0);

        // New command partway through hold cancels the release
        send(16'd1, 1'b1, 2'd2, 24'd2);
        tick(2);
        chk("t5_short_done", {31'd0, done}, 32'd1);
        tick(9);
        send(16'd2, 1'b1, 2'd2, 24'd2);
        chk("t5_restart", {26'd0, busy, drv_enable, coil}, 32'h33);
        tick(6);
        chk("t5_kept_on", {27'd0, drv_enable, coil}, 32'h16);

        // Zero-step command while energised
        send(16'd0, 1'b1, 2'd2, 24'd2);
        chk("e_zero_done", {31'd0, done}, 32'd1);
        chk("e_zero_coil", {27'd0, drv_enable, coil}, 32'h16);
        chk("e_zero_busy", {30'd0, busy, cmd_ready}, 32'd1);
        tick(1);
        chk("e_zero_pulse", {31'd0, done}, 32'd0);

        // abort outside RUN has no effect
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("e_abort_idle", {30'd0, done, aborted}, 32'd0);

        // De-energise command
        send(16'd5, 1'b1, 2'd3, 24'd2);
        chk("e_off_coil", {27'd0, drv_enable, coil}, 32'h00);
        chk("e_off_done", {30'd0, done, busy}, 32'd2);
        chk("e_off_idx", {29'd0, phase_index}, 32'd3);

        // Zero-step command while de-energised
        send(16'd0, 1'b1, 2'd2, 24'd2);
        chk("e_zero_idle", {27'd0, drv_enable, coil}, 32'h00);
        chk("e_zero_idle_done", {31'd0, done}, 32'd1);

        // Period 0 behaves as 2
        send(16'd1, 1'b1, 2'd2, 24'd0);
        chk("e_p0_coil", {28'd0, coil}, 32'd6);
        tick(1);
        chk("e_p0_wait", {29'd0, phase_index}, 32'd3);
        tick(1);
        chk("e_p0_step", {29'd0, phase_index}, 32'd4);
        chk("e_p0_done", {31'd0, done}, 32'd1);

        // cmd_valid held through a move
        send(16'd2, 1'b1, 2'd2, 24'd2);
        cmd_steps  = 16'd1;
        cmd_dir    = 1'b0;
        cmd_mode   = 2'd2;
        cmd_period = 24'd2;
        cmd_valid  = 1'b1;
        tick(1);
        chk("e_held_ready", {30'd0, cmd_ready, busy}, 32'd1);
        tick(3);
        chk("e_held_done", {30'd0, done, cmd_ready}, 32'd3);
        chk("e_held_idx", {29'd0, phase_index}, 32'd6);
        tick(1);
        cmd_valid = 1'b0;
        chk("e_held_accept", {30'd0, busy, done}, 32'd2);
        tick(2);
        chk("e_held_idx2", {29'd0, phase_index}, 32'd5);
        chk("e_held_done2", {31'd0, done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
